// File: rtl/calc_core_cmd_issuer_pkg.sv
// Shared definitions for the calculation-core command issuer: inputmode codes,
// controller states, default widths and command field layout.
package calc_core_cmd_issuer_pkg;

  localparam int unsigned DEF_WORD_SIZE      = 384;
  localparam int unsigned DEF_RAM_ADDR_SIZE  = 6;
  localparam int unsigned DEF_MODE_SIZE      = 4;
  localparam int unsigned DEF_CMD_SIZE       = DEF_MODE_SIZE + 3 * DEF_RAM_ADDR_SIZE;
  localparam int unsigned DEF_CMD_FIFO_DEPTH = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

  // Core I_INPUTMODE codes
  localparam logic [1:0] IM_IDLE  = 2'd0;
  localparam logic [1:0] IM_COORD = 2'd1;
  localparam logic [1:0] IM_EXEC  = 2'd2;
  localparam logic [1:0] IM_REF   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StRead,
    StFin
  } state_e;

  // Command fields, listed LSB first; each address field is RAM_ADDR_SIZE wide
  localparam int unsigned CMD_RET  = 0;
  localparam int unsigned CMD_OPR2 = 1;
  localparam int unsigned CMD_OPR1 = 2;
  localparam int unsigned CMD_MODE = 3;

  function automatic int unsigned cmd_field_lsb(input int unsigned field,
                                                input int unsigned addr_size);
    return field * addr_size;
  endfunction

  function automatic logic [DEF_CMD_SIZE-1:0] pack_cmd(
    input logic [DEF_MODE_SIZE-1:0]     mode,
    input logic [DEF_RAM_ADDR_SIZE-1:0] opr1,
    input logic [DEF_RAM_ADDR_SIZE-1:0] opr2,
    input logic [DEF_RAM_ADDR_SIZE-1:0] ret
  );
    return {mode, opr1, opr2, ret};
  endfunction

endpackage

// File: rtl/calc_core_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags, occupancy count
// and a single-cycle flush. Head is presented combinationally on dout.
module calc_core_cmd_issuer_cmd_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Occupancy after this cycle's accepted push/pop
  always_comb begin
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  // Pointers, count and flags; flush drops everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage; no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/calc_core_cmd_issuer.sv
// Host-side controller for one calculation core: loads operands, queues and
// issues ALU commands, waits on the core finish flag and reads results back.
module calc_core_cmd_issuer
  import calc_core_cmd_issuer_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
  parameter int unsigned RAM_ADDR_SIZE  = DEF_RAM_ADDR_SIZE,
  parameter int unsigned MODE_SIZE      = DEF_MODE_SIZE,
  parameter int unsigned CMD_SIZE       = DEF_CMD_SIZE,
  parameter int unsigned CMD_FIFO_DEPTH = DEF_CMD_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [RAM_ADDR_SIZE-1:0] ld_addr1,
  input  logic [RAM_ADDR_SIZE-1:0] ld_addr2,
  input  logic [WORD_SIZE-1:0]     ld_data1,
  input  logic [WORD_SIZE-1:0]     ld_data2,
  input  logic                     ld_en2,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CMD_SIZE-1:0]      cmd_data,
  input  logic                     run_start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [RAM_ADDR_SIZE-1:0] rd_addr1,
  input  logic [RAM_ADDR_SIZE-1:0] rd_addr2,
  output logic                     rd_rsp_valid,
  output logic [WORD_SIZE-1:0]     rd_data1,
  output logic [WORD_SIZE-1:0]     rd_data2,
  output logic [1:0]               core_inputmode,
  output logic [CMD_SIZE-1:0]      core_cmd,
  output logic [RAM_ADDR_SIZE-1:0] core_waddr1,
  output logic [RAM_ADDR_SIZE-1:0] core_waddr2,
  output logic [WORD_SIZE-1:0]     core_wdata1,
  output logic [WORD_SIZE-1:0]     core_wdata2,
  output logic [RAM_ADDR_SIZE-1:0] core_raddr1,
  output logic [RAM_ADDR_SIZE-1:0] core_raddr2,
  input  logic [WORD_SIZE-1:0]     core_out1,
  input  logic [WORD_SIZE-1:0]     core_out2,
  input  logic                     core_finished
);

  localparam int unsigned CmdW     = MODE_SIZE + 3 * RAM_ADDR_SIZE;
  localparam int unsigned WdogW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CmdW-1:0]          cmd_q;
  logic [WdogW-1:0]         wdog_q;
  logic                     err_q;
  logic                     ld_pend_q;
  logic [RAM_ADDR_SIZE-1:0] waddr1_q, waddr2_q, raddr1_q, raddr2_q;
  logic [WORD_SIZE-1:0]     wdata1_q, wdata2_q, rdata1_q, rdata2_q;
  logic                     rsp_valid_q;

  logic                     fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CmdW-1:0]          fifo_head;
  logic [$clog2(CMD_FIFO_DEPTH):0] unused_fifo_count;
  logic                     ld_fire, rd_fire, wdog_expire;

  calc_core_cmd_issuer_cmd_fifo #(
    .WIDTH(CmdW),
    .DEPTH(CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .din  (cmd_data),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(unused_fifo_count)
  );

  // Run start wins over readback, readback wins over operand loads
  assign ld_ready     = (state_q == StIdle) && !run_start && !rd_req_valid;
  assign rd_req_ready = (state_q == StIdle) && !run_start;
  assign ld_fire      = ld_valid && ld_ready;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  // Next-state, FIFO pop/flush and watchdog expiry
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    wdog_expire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_start) begin
          state_d = fifo_empty ? StFin : StIssue;
        end else if (rd_req_valid) begin
          state_d = StRead;
        end
      end
      StIssue: begin
        fifo_pop = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (core_finished) begin
          state_d = StGap;
        end else if (wdog_q == WdogLast) begin
          wdog_expire = 1'b1;
          fifo_flush  = 1'b1;
          state_d     = StFin;
        end
      end
      StGap:   state_d = fifo_empty ? StFin : StIssue;
      StRead:  state_d = StIdle;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, command, watchdog, load/readback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      ld_pend_q   <= 1'b0;
      waddr1_q    <= '0;
      waddr2_q    <= '0;
      wdata1_q    <= '0;
      wdata2_q    <= '0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIssue) cmd_q <= fifo_head;
      wdog_q <= (state_q == StWait) ? wdog_q + 1'b1 : '0;
      if ((state_q == StIdle) && run_start) begin
        err_q <= 1'b0;
      end else if (wdog_expire) begin
        err_q <= 1'b1;
      end
      ld_pend_q <= ld_fire;
      if (ld_fire) begin
        // Core writes both lanes, so a single-lane beat duplicates lane 1
        waddr1_q <= ld_addr1;
        wdata1_q <= ld_data1;
        waddr2_q <= ld_en2 ? ld_addr2 : ld_addr1;
        wdata2_q <= ld_en2 ? ld_data2 : ld_data1;
      end
      if (rd_fire) begin
        raddr1_q <= rd_addr1;
        raddr2_q <= rd_addr2;
      end
      rsp_valid_q <= (state_q == StRead);
      if (state_q == StRead) begin
        rdata1_q <= core_out1;
        rdata2_q <= core_out2;
      end
    end
  end

  // Inputmode decode; GAP and ISSUE fall to IM_IDLE so the core resets its sequencer
  always_comb begin
    core_inputmode = IM_IDLE;
    if (state_q == StWait) begin
      core_inputmode = IM_EXEC;
    end else if (state_q == StRead) begin
      core_inputmode = IM_REF;
    end else if (ld_pend_q) begin
      core_inputmode = IM_COORD;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFin);
  assign err          = err_q;
  assign core_cmd     = cmd_q;
  assign core_waddr1  = waddr1_q;
  assign core_waddr2  = waddr2_q;
  assign core_wdata1  = wdata1_q;
  assign core_wdata2  = wdata2_q;
  assign core_raddr1  = raddr1_q;
  assign core_raddr2  = raddr2_q;
  assign rd_rsp_valid = rsp_valid_q;
  assign rd_data1     = rdata1_q;
  assign rd_data2     = rdata2_q;

endmodule
